uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4; number of requesters, legal range 2..8.
REQ-002 SHALL have parameter CLK_HZ, default 50_000_000; system clock frequency, informational only (the divisor table assumes 50 MHz).
REQ-003 SHALL have port clk, input, 1 bit; single system clock, with all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit; asynchronous, active-high reset.
REQ-005 SHALL have port baud_sel, input, 3 bits; selects 0=9600, 1=19200, 2=38400, 3=57600, 4=115200 bps, with 5..7 treated as 0.
REQ-006 SHALL have port req, input, NREQ bits; per-requester level request.
REQ-007 SHALL have port data, input, NREQ*8 bits; byte i occupies bits [8i+7:8i].
REQ-008 SHALL have port gnt, output, NREQ bits; one-hot, one-cycle acceptance pulse.
REQ-009 SHALL have port owner, output, 3 bits; index of the last granted requester.
REQ-010 SHALL have port busy, output, 1 bit; high while a frame is in flight.
REQ-011 SHALL have port txd, output, 1 bit; serial line, idle high.

Function
REQ-012 SHALL implement the FSM states IDLE, START, DATA, PARITY (macro only), STOP.
REQ-013 SHALL, in IDLE with any req bit high at edge k, assert gnt for exactly cycle k+1, latch the byte and baud_sel, enter START, and drive txd=0 from cycle k+1.
REQ-014 SHALL arbitrate round-robin: search starts at pointer, which resets to 0 and becomes (granted index+1) mod NREQ after each grant.
REQ-015 SHALL hold each bit for DIV+1 clocks, with DIV from the package table: 5207, 2603, 1301, 867, 433.
REQ-016 SHALL use a bit-timer that counts 0..DIV, wraps to 0, and generates the bit-end tick at DIV.
REQ-017 SHALL clear the bit-timer on every grant.
REQ-018 SHALL send the frame as start(0), 8 data bits LSB first, optional parity, then stop(1).
REQ-019 SHALL, at the end of the stop bit, enter IDLE with txd=1.
REQ-020 SHALL guarantee at least one idle-high cycle between back-to-back frames.
REQ-021 SHALL ignore baud_sel, req, and data changes during a frame; only latched values are used.
REQ-022 SHALL treat req still high after gnt as a new request, eligible only after the frame ends and subject to round-robin order.
REQ-023 SHALL drop a request that is deasserted before it is granted, with no side effect.
REQ-024 SHALL hold busy=1 from the grant cycle through the last stop-bit cycle, and 0 otherwise.
REQ-025 SHALL hold owner at the last granted index; owner is 0 after reset.

Reset
REQ-026 SHALL, while rst=1 (asynchronously, including mid-frame), force txd=1, gnt=0, busy=0, owner=0, pointer=0, bit-timer=0, and state=IDLE.
REQ-027 SHALL discard any partially sent frame on reset, with no resumption.
REQ-028 SHALL allow the first grant no earlier than the first clk edge after rst falls.

Configuration
REQ-029 SHALL, when macro UART_TX_ARBITER_PARITY_EN is defined, insert an even-parity bit (XOR of the 8 data bits) after the data bits, giving an 11-bit frame.
REQ-030 SHALL, without the macro, have no PARITY state and send a 10-bit frame; ports are identical in both builds.

Structure
REQ-031 SHALL place the baud_sel encodings, the divisor table, the FSM state typedef, and the frame-length constants in shared package uart_pkg.
REQ-032 SHALL instantiate sub-module uart_baud_tick (inputs: clk, rst, clr, div; output: tick) for the bit-timer.
REQ-033 SHALL keep arbitration and the FSM in the top module.

Verification
REQ-034 SHALL verify single request: req=0001, data0=0x55, baud_sel=4 -> gnt=0001 for 1 cycle; txd shows bits 0,1,0,1,0,1,0,1,0,1, each 434 clocks; busy low after 4340 clocks.
REQ-035 SHALL verify fairness: req=1111 held continuously -> grant order 0,1,2,3,0, with exactly one idle-high cycle between frames.
REQ-036 SHALL verify mid-frame changes: baud_sel changes 4->0 and data changes mid-frame -> bit width stays 434 clocks and the latched byte is sent unchanged.
REQ-037 SHALL verify reset mid-frame: rst pulse during DATA -> txd=1 and busy=0 immediately (asynchronously); the next grant goes to requester 0.
REQ-038 SHALL verify parity build: with UART_TX_ARBITER_PARITY_EN, data=0x07 -> parity bit 1 and an 11-bit frame; without the macro, a 10-bit frame.
REQ-039 SHALL verify illegal baud_sel: baud_sel=6 -> bit width 5208 clocks.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART constants: baud encodings, divisor table (50 MHz clock), FSM states, frame lengths.
// Build option: UART_TX_ARBITER_PARITY_EN adds the PARITY state and an even-parity bit (11-bit frame).
package uart_pkg;

    localparam int unsigned DIV_W     = 13;
    localparam int unsigned DATA_BITS = 8;

    localparam logic [2:0] BAUD_9600   = 3'd0;
    localparam logic [2:0] BAUD_19200  = 3'd1;
    localparam logic [2:0] BAUD_38400  = 3'd2;
    localparam logic [2:0] BAUD_57600  = 3'd3;
    localparam logic [2:0] BAUD_115200 = 3'd4;

    // Each bit lasts DIV+1 clocks.
    localparam logic [DIV_W-1:0] DIV_9600   = 13'd5207;
    localparam logic [DIV_W-1:0] DIV_19200  = 13'd2603;
    localparam logic [DIV_W-1:0] DIV_38400  = 13'd1301;
    localparam logic [DIV_W-1:0] DIV_57600  = 13'd867;
    localparam logic [DIV_W-1:0] DIV_115200 = 13'd433;

`ifdef UART_TX_ARBITER_PARITY_EN
    localparam int unsigned FRAME_BITS = 11;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;
`else
    localparam int unsigned FRAME_BITS = 10;
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} tx_state_t;
`endif

    function automatic logic [DIV_W-1:0] baud_div(input logic [2:0] sel);
        case (sel)
            BAUD_9600:   baud_div = DIV_9600;
            BAUD_19200:  baud_div = DIV_19200;
            BAUD_38400:  baud_div = DIV_38400;
            BAUD_57600:  baud_div = DIV_57600;
            BAUD_115200: baud_div = DIV_115200;
            default:     baud_div = DIV_9600;
        endcase
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit timer: counts 0..div, wraps to 0, and ticks on the last clock of each bit period.
module uart_baud_tick
    import uart_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] cnt;

    assign tick = (cnt == div);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding a single 8N1 UART transmitter; the granted byte and baud are latched per frame.
// Build option: UART_TX_ARBITER_PARITY_EN inserts an even-parity bit after the data bits.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NREQ   = 4,
    parameter int CLK_HZ = 50_000_000
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        baud_sel,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*8-1:0] data,
    output logic [NREQ-1:0]   gnt,
    output logic [2:0]        owner,
    output logic              busy,
    output logic              txd
);

    if (NREQ < 2 || NREQ > 8 || CLK_HZ <= 0) begin : g_param_check
        $error("uart_tx_arbiter: NREQ must be in 2..8 and CLK_HZ positive");
    end

    tx_state_t        state;
    tx_state_t        state_n;
    logic [2:0]       ptr;
    logic [DIV_W-1:0] div_q;
    logic [7:0]       shreg;
    logic [2:0]       bit_idx;
    logic             tick;
    logic             load;
    logic             found;
    logic [2:0]       sel_idx;
    logic [3:0]       cand;
    logic [7:0]       sel_byte;
`ifdef UART_TX_ARBITER_PARITY_EN
    logic             par;
`endif

    uart_baud_tick u_baud_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (state == IDLE),
        .div  (div_q),
        .tick (tick)
    );

    // Visit candidates in order ptr, ptr+1, ... (mod NREQ); first requester wins.
    always_comb begin
        found   = 1'b0;
        sel_idx = '0;
        cand    = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            cand = {1'b0, ptr} + 4'(i);
            if (cand >= 4'(NREQ)) cand = cand - 4'(NREQ);
            for (int unsigned c = 0; c < NREQ; c++) begin
                if (!found && cand == 4'(c) && req[c]) begin
                    found   = 1'b1;
                    sel_idx = 3'(c);
                end
            end
        end
    end

    always_comb begin
        sel_byte = '0;
        for (int unsigned c = 0; c < NREQ; c++) begin
            if (sel_idx == 3'(c)) sel_byte = data[c*8 +: 8];
        end
    end

    always_comb begin
        state_n = state;
        load    = 1'b0;
        case (state)
            IDLE:   if (found) begin
                        state_n = START;
                        load    = 1'b1;
                    end
            START:  if (tick) state_n = DATA;
`ifdef UART_TX_ARBITER_PARITY_EN
            DATA:   if (tick && bit_idx == 3'(DATA_BITS-1)) state_n = PARITY;
            PARITY: if (tick) state_n = STOP;
`else
            DATA:   if (tick && bit_idx == 3'(DATA_BITS-1)) state_n = STOP;
`endif
            STOP:   if (tick) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt     <= '0;
            owner   <= '0;
            ptr     <= '0;
            div_q   <= '0;
            shreg   <= '0;
            bit_idx <= '0;
`ifdef UART_TX_ARBITER_PARITY_EN
            par     <= 1'b0;
`endif
        end else begin
            gnt <= '0;
            if (load) begin
                gnt     <= {{(NREQ-1){1'b0}}, 1'b1} << sel_idx;
                owner   <= sel_idx;
                ptr     <= (sel_idx == 3'(NREQ-1)) ? '0 : sel_idx + 3'd1;
                div_q   <= baud_div(baud_sel);
                shreg   <= sel_byte;
                bit_idx <= '0;
`ifdef UART_TX_ARBITER_PARITY_EN
                par     <= ^sel_byte;
`endif
            end else if (state == DATA && tick) begin
                shreg   <= shreg >> 1;
                bit_idx <= bit_idx + 3'd1;
            end
        end
    end

    // txd and busy decode straight from state so an asynchronous reset idles the line at once.
    always_comb begin
        case (state)
            START:   txd = 1'b0;
            DATA:    txd = shreg[0];
`ifdef UART_TX_ARBITER_PARITY_EN
            PARITY:  txd = par;
`endif
            default: txd = 1'b1;
        endcase
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter (NREQ=4); expected frame lengths follow UART_TX_ARBITER_PARITY_EN.
module tb_uart_tx_arbiter;
    import uart_pkg::*;

    localparam int BIT_W = 434;

`ifdef UART_TX_ARBITER_PARITY_EN
    localparam int RUN8 = 2 * BIT_W;   // bit7=0 of 0x55 merges with parity=0
`else
    localparam int RUN8 = BIT_W;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  baud_sel = 3'd4;
    logic [3:0]  req = '0;
    logic [31:0] data = '0;
    logic [3:0]  gnt;
    logic [2:0]  owner;
    logic        busy;
    logic        txd;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    uart_tx_arbiter #(.NREQ(4), .CLK_HZ(50_000_000)) dut (
        .clk      (clk),
        .rst      (rst),
        .baud_sel (baud_sel),
        .req      (req),
        .data     (data),
        .gnt      (gnt),
        .owner    (owner),
        .busy     (busy),
        .txd      (txd)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Counts consecutive negedge samples at the current txd level; returns on the first sample of a new level.
    task automatic run_len(output int n);
        logic lvl;
        lvl = txd;
        n = 0;
        while (txd == lvl && n < 60000) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic wait_gnt(input int bound, output int idle);
        int n;
        idle = 0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (gnt == 4'b0000 && !busy && txd) idle++;
        end while (gnt == 4'b0000 && n < bound);
    endtask

    task automatic wait_idle(input int bound);
        int n;
        n = 0;
        while (busy && n < bound) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        int n;
        int idle;
        int c0;
        logic [7:0] rx;
        logic bad;
        logic [3:0] order [5];
        order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

        do_reset();
        check("rst_txd", 32'(txd), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_owner", 32'(owner), 32'd0);

        // single request, 0x55 at 115200
        baud_sel = 3'd4;
        data = 32'h0000_0055;
        req = 4'b0001;
        @(negedge clk);
        check("t1_gnt", 32'(gnt), 32'h1);
        check("t1_busy", 32'(busy), 32'd1);
        check("t1_txd_start", 32'(txd), 32'd0);
        req = '0;
        @(negedge clk);
        check("t1_gnt_pulse", 32'(gnt), 32'd0);
        check("t1_owner", 32'(owner), 32'd0);
        run_len(n);
        check("t1_run0", 32'(n), 32'(BIT_W - 1));
        for (int r = 1; r < 8; r++) begin
            run_len(n);
            check($sformatf("t1_run%0d", r), 32'(n), 32'(BIT_W));
        end
        run_len(n);
        check("t1_run8", 32'(n), 32'(RUN8));
        repeat (BIT_W - 1) @(negedge clk);
        check("t1_busy_last_stop", 32'(busy), 32'd1);
        @(negedge clk);
        check("t1_busy_end", 32'(busy), 32'd0);
        check("t1_txd_idle", 32'(txd), 32'd1);

        // fairness with all requests held
        do_reset();
        data = 32'h4433_2211;
        req = 4'b1111;
        for (int f = 0; f < 5; f++) begin
            wait_gnt(6000, idle);
            check($sformatf("t2_gnt%0d", f), 32'(gnt), 32'(order[f]));
            if (f > 0) check($sformatf("t2_idle%0d", f), 32'(idle), 32'd1);
        end
        req = '0;
        wait_idle(6000);
        check("t2_done", 32'(busy), 32'd0);

        // mid-frame baud/data changes; dropped request (pointer now at 1)
        baud_sel = 3'd4;
        data = 32'h0000_0700;
        req = 4'b0010;
        @(negedge clk);
        c0 = cyc;
        check("t3_gnt", 32'(gnt), 32'h2);
        req = 4'b1000;
        @(negedge clk);
        check("t3_owner", 32'(owner), 32'd1);
        req = '0;
        baud_sel = 3'd0;
        data = 32'h0000_0000;
        run_len(n);
        check("t3_start", 32'(n), 32'(BIT_W - 1));
        for (int b = 0; b < 8; b++) begin
            repeat (BIT_W / 2) @(negedge clk);
            rx[b] = txd;
            repeat (BIT_W - BIT_W / 2) @(negedge clk);
        end
        check("t3_byte", 32'(rx), 32'h07);
        wait_idle(6000);
        check("t3_frame_len", 32'(cyc - c0), 32'(FRAME_BITS * BIT_W));
        bad = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (gnt != 4'b0000 || busy) bad = 1'b1;
        end
        check("t3_drop_no_grant", 32'(bad), 32'd0);

        // async reset mid-frame (pointer now at 2)
        baud_sel = 3'd4;
        data = 32'h0000_0000;
        req = 4'b0100;
        @(negedge clk);
        check("t4_gnt", 32'(gnt), 32'h4);
        req = '0;
        repeat (1000) @(negedge clk);
        check("t4_txd_data", 32'(txd), 32'd0);
        #2 rst = 1'b1;
        #1;
        check("t4_rst_txd", 32'(txd), 32'd1);
        check("t4_rst_busy", 32'(busy), 32'd0);
        check("t4_rst_owner", 32'(owner), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        req = 4'b1111;
        @(negedge clk);
        check("t4_gnt_after_rst", 32'(gnt), 32'h1);
        do_reset();

        // illegal baud_sel falls back to 9600
        baud_sel = 3'd6;
        data = 32'h0000_0007;
        req = 4'b0001;
        @(negedge clk);
        check("t5_gnt", 32'(gnt), 32'h1);
        req = '0;
        @(negedge clk);
        run_len(n);
        check("t5_start", 32'(n), 32'd5207);
        do_reset();
        check("t5_rst_txd", 32'(txd), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
